rename_map: RTL and testbench
=============================

Name: rename_map

Overview:
- Single-issue register rename stage. Sits between decode and dispatch, directly upstream consumer of free_list.
- Translates architectural sources/dest to physical tags using a speculative map table (SMT), pops one physical register from free_list per renamed writer, and tracks per-preg ready bits.
- Keeps a committed map table (CMT) for flush recovery.
- Produces a registered rename packet, including the old dest mapping that ROB later returns to free_list.

Parameters:
- ARCH_REGS, 32, architectural registers; index 31 is XZR and is never renamed
- PHYS_REGS, core_pkg::PREGS (64), physical registers; tag width 6

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  decode packet valid
- in_ready  out  1  stage accepts packet this cycle
- rs1_arch, rs2_arch  in  5 each  source arch regs
- rd_arch  in  5  dest arch reg
- rd_wen  in  1  instruction writes rd
- alloc_en  out  1  pop request to free_list
- alloc_phys  in  6  free_list head tag, valid same cycle
- alloc_valid  in  1  free_list non-empty
- out_valid  out  1  rename packet valid
- out_ready  in  1  dispatch accepts packet
- out_ps1, out_ps2  out  6 each  source phys tags
- out_ps1_rdy, out_ps2_rdy  out  1 each  source operand ready
- out_pd  out  6  new dest tag
- out_old_pd  out  6  previous mapping of rd
- out_rd_wen  out  1  packet allocated a dest
- wb_en  in  1  writeback wakeup
- wb_phys  in  6  tag written back
- commit_en  in  1  ROB retires a writer
- commit_rd_arch  in  5  retired arch dest
- commit_pd  in  6  retired phys dest
- flush  in  1  mispredict/exception recovery

Behaviour:
- Reset: SMT[i]=CMT[i]=i for all i; ready[] all 1; out_valid=0; all out_* data=0; alloc_en=0.
- Integration: free_list must start with tags ARCH_REGS..PHYS_REGS-1 free.
- needs_alloc = rd_wen && rd_arch!=31.
- in_ready = (!out_valid || out_ready) && !flush && (!needs_alloc || alloc_valid). This is combinational.
- fire = in_valid && in_ready; alloc_en = fire && needs_alloc, combinational, so free_list pops at the same edge.
- On fire, at the edge:
  - out_valid<=1.
  - out_ps1<=SMT[rs1_arch]; out_ps2<=SMT[rs2_arch].
  - out_psN_rdy<=ready[tag] | (wb_en && wb_phys==tag); arch 31 is always ready.
  - If needs_alloc: out_pd<=alloc_phys, out_old_pd<=SMT[rd_arch], out_rd_wen<=1, SMT[rd_arch]<=alloc_phys, ready[alloc_phys]<=0.
  - Else: out_pd=0, out_old_pd=0, out_rd_wen=0.
- Source lookup reads the SMT before this packet's own rd update: for rd==rs1, the source gets the old tag.
- When out_valid && out_ready && !fire: out_valid<=0.
- When out_valid && !out_ready: all out_* are held stable.
- wb_en: ready[wb_phys]<=1. If it coincides with an alloc of the same tag, the clear wins.
- commit_en: CMT[commit_rd_arch]<=commit_pd. commit_rd_arch==31 is ignored.
- flush, which has priority over fire:
  - SMT<=CMT, including a same-cycle commit, which is forwarded.
  - ready[] all set to 1.
  - out_valid<=0; no alloc. in_ready=0 during the flush cycle.
  - Free-list recovery is owned by the ROB/free_list.
- reset mid-operation has priority over flush, commit, and wb and restores the reset state.
- Free list empty with a writer pending: in_ready=0, the packet stalls, and no state changes.

Optional Feature:
- Macro RENAME_STALL_CNT_EN.
- When defined: adds output stall_cycles, 32-bit.
  - Reset to 0.
  - Increments each cycle in_valid && needs_alloc && !alloc_valid && !flush.
  - Saturates at all-ones.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then rename rs1=1, rs2=2, rd=3, alloc_phys=32 -> out_ps1=1, out_ps2=2, both rdy=1, out_pd=32, out_old_pd=3; next packet with rs1=3 -> out_ps1=32, out_ps1_rdy=0.
- rd=5, rs1=5, alloc_phys=33 -> out_ps1=5 (old mapping), out_pd=33, out_old_pd=5; rd=31 with rd_wen=1 -> alloc_en=0, out_rd_wen=0.
- alloc_valid=0 with a writer -> in_ready=0, alloc_en=0, SMT unchanged; raising alloc_valid next cycle -> fire with the presented tag.
- out_ready=0 for 3 cycles -> out_* held, in_ready=0; wb_en with wb_phys=32 in the same cycle a source maps to 32 -> out_ps1_rdy=1.
- Rename rd=4->34, commit (4,34), rename rd=4->35, flush -> subsequent rs1=4 reads 34, rdy=1; flush with in_valid=1 -> no fire, out_valid=0.
- With RENAME_STALL_CNT_EN defined, hold a writer with alloc_valid=0 for 7 cycles -> stall_cycles=7; reset -> 0.

Source files
------------

// File: rtl/rename_map.sv
// Single-issue register rename stage: speculative/committed map tables, per-preg ready bits,
// registered rename packet. Optional stall counter enabled by macro RENAME_STALL_CNT_EN.
module rename_map #(
  parameter int unsigned ARCH_REGS = 32,
  parameter int unsigned PHYS_REGS = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [$clog2(ARCH_REGS)-1:0]   rs1_arch,
  input  logic [$clog2(ARCH_REGS)-1:0]   rs2_arch,
  input  logic [$clog2(ARCH_REGS)-1:0]   rd_arch,
  input  logic                           rd_wen,
  output logic                           alloc_en,
  input  logic [$clog2(PHYS_REGS)-1:0]   alloc_phys,
  input  logic                           alloc_valid,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [$clog2(PHYS_REGS)-1:0]   out_ps1,
  output logic [$clog2(PHYS_REGS)-1:0]   out_ps2,
  output logic                           out_ps1_rdy,
  output logic                           out_ps2_rdy,
  output logic [$clog2(PHYS_REGS)-1:0]   out_pd,
  output logic [$clog2(PHYS_REGS)-1:0]   out_old_pd,
  output logic                           out_rd_wen,
  input  logic                           wb_en,
  input  logic [$clog2(PHYS_REGS)-1:0]   wb_phys,
  input  logic                           commit_en,
  input  logic [$clog2(ARCH_REGS)-1:0]   commit_rd_arch,
  input  logic [$clog2(PHYS_REGS)-1:0]   commit_pd,
  input  logic                           flush
`ifdef RENAME_STALL_CNT_EN
  ,
  output logic [31:0]                    stall_cycles
`endif
);

  localparam int unsigned AW = $clog2(ARCH_REGS);
  localparam int unsigned TW = $clog2(PHYS_REGS);
  localparam logic [AW-1:0] XZR = AW'(ARCH_REGS - 1);

  logic [TW-1:0]        smt [ARCH_REGS];
  logic [TW-1:0]        cmt [ARCH_REGS];
  logic [PHYS_REGS-1:0] ready;

  logic          needs_alloc;
  logic          fire;
  logic          commit_ok;
  logic [TW-1:0] ps1;
  logic [TW-1:0] ps2;
  logic          ps1_rdy;
  logic          ps2_rdy;

  // Handshake, allocation request and source lookup (pre-update SMT, wakeup bypass)
  always_comb begin
    needs_alloc = rd_wen && (rd_arch != XZR);
    in_ready    = (!out_valid || out_ready) && !flush && (!needs_alloc || alloc_valid);
    fire        = in_valid && in_ready;
    alloc_en    = fire && needs_alloc;
    commit_ok   = commit_en && (commit_rd_arch != XZR);
    ps1         = smt[rs1_arch];
    ps2         = smt[rs2_arch];
    ps1_rdy     = (rs1_arch == XZR) || ready[ps1] || (wb_en && (wb_phys == ps1));
    ps2_rdy     = (rs2_arch == XZR) || ready[ps2] || (wb_en && (wb_phys == ps2));
  end

  // Speculative map; flush restores the committed map with same-cycle commit forwarded
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < ARCH_REGS; i++) smt[i] <= TW'(i);
    end else if (flush) begin
      for (int unsigned i = 0; i < ARCH_REGS; i++)
        smt[i] <= (commit_ok && (commit_rd_arch == AW'(i))) ? commit_pd : cmt[i];
    end else if (alloc_en) begin
      smt[rd_arch] <= alloc_phys;
    end
  end

  // Committed map
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < ARCH_REGS; i++) cmt[i] <= TW'(i);
    end else if (commit_ok) begin
      cmt[commit_rd_arch] <= commit_pd;
    end
  end

  // Ready bits; an allocation clear overrides a same-tag wakeup
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      ready <= '1;
    end else begin
      if (wb_en)    ready[wb_phys]    <= 1'b1;
      if (alloc_en) ready[alloc_phys] <= 1'b0;
    end
  end

  // Rename packet register; held while dispatch back-pressures
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_ps1     <= '0;
      out_ps2     <= '0;
      out_ps1_rdy <= 1'b0;
      out_ps2_rdy <= 1'b0;
      out_pd      <= '0;
      out_old_pd  <= '0;
      out_rd_wen  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (fire) begin
      out_valid   <= 1'b1;
      out_ps1     <= ps1;
      out_ps2     <= ps2;
      out_ps1_rdy <= ps1_rdy;
      out_ps2_rdy <= ps2_rdy;
      out_pd      <= needs_alloc ? alloc_phys   : '0;
      out_old_pd  <= needs_alloc ? smt[rd_arch] : '0;
      out_rd_wen  <= needs_alloc;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef RENAME_STALL_CNT_EN
  // Saturating count of cycles a writer waits on an empty free list
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (in_valid && needs_alloc && !alloc_valid && !flush && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rename_map.sv
// Directed scoreboard bench for rename_map; expected packets are queued at issue and
// compared when the DUT presents them.
module tb_rename_map;

  logic       clk = 1'b0;
  logic       reset, in_valid, in_ready, rd_wen, alloc_en, alloc_valid;
  logic [4:0] rs1_arch, rs2_arch, rd_arch, commit_rd_arch;
  logic [5:0] alloc_phys, out_ps1, out_ps2, out_pd, out_old_pd, wb_phys, commit_pd;
  logic       out_valid, out_ready, out_ps1_rdy, out_ps2_rdy, out_rd_wen;
  logic       wb_en, commit_en, flush;
`ifdef RENAME_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  typedef struct packed {
    logic [5:0] ps1;
    logic [5:0] ps2;
    logic       r1;
    logic       r2;
    logic [5:0] pd;
    logic [5:0] old;
    logic       wen;
  } pkt_t;

  pkt_t sb[$];
  int   checks = 0;
  int   errors = 0;

  rename_map dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .rs1_arch(rs1_arch), .rs2_arch(rs2_arch), .rd_arch(rd_arch), .rd_wen(rd_wen),
    .alloc_en(alloc_en), .alloc_phys(alloc_phys), .alloc_valid(alloc_valid),
    .out_valid(out_valid), .out_ready(out_ready), .out_ps1(out_ps1), .out_ps2(out_ps2),
    .out_ps1_rdy(out_ps1_rdy), .out_ps2_rdy(out_ps2_rdy), .out_pd(out_pd),
    .out_old_pd(out_old_pd), .out_rd_wen(out_rd_wen), .wb_en(wb_en), .wb_phys(wb_phys),
    .commit_en(commit_en), .commit_rd_arch(commit_rd_arch), .commit_pd(commit_pd),
    .flush(flush)
`ifdef RENAME_STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  function automatic pkt_t mk(input logic [5:0] ps1, input logic [5:0] ps2, input logic r1,
                              input logic r2, input logic [5:0] pd, input logic [5:0] old,
                              input logic wen);
    pkt_t p;
    p.ps1 = ps1; p.ps2 = ps2; p.r1 = r1; p.r2 = r2; p.pd = pd; p.old = old; p.wen = wen;
    return p;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cmp_pkt(input string tag, input pkt_t e);
    chk({tag, ".out_valid"},   32'(out_valid),   32'd1);
    chk({tag, ".out_ps1"},     32'(out_ps1),     32'(e.ps1));
    chk({tag, ".out_ps2"},     32'(out_ps2),     32'(e.ps2));
    chk({tag, ".out_ps1_rdy"}, 32'(out_ps1_rdy), 32'(e.r1));
    chk({tag, ".out_ps2_rdy"}, 32'(out_ps2_rdy), 32'(e.r2));
    chk({tag, ".out_pd"},      32'(out_pd),      32'(e.pd));
    chk({tag, ".out_old_pd"},  32'(out_old_pd),  32'(e.old));
    chk({tag, ".out_rd_wen"},  32'(out_rd_wen),  32'(e.wen));
  endtask

  // Compare the presented packet with the scoreboard head and retire it
  task automatic check_out(input string tag);
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL %s.sb_empty observed=0 expected=1", tag);
    end
    if (sb.size() != 0) cmp_pkt(tag, sb.pop_front());
  endtask

  task automatic peek_out(input string tag);
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL %s.sb_empty observed=0 expected=1", tag);
    end
    if (sb.size() != 0) cmp_pkt(tag, sb[0]);
  endtask

  task automatic issue(input string tag, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd, input logic wen, input logic [5:0] phys,
                       input logic exp_alloc, input pkt_t e);
    in_valid = 1'b1; rs1_arch = r1; rs2_arch = r2; rd_arch = rd; rd_wen = wen;
    alloc_phys = phys; alloc_valid = 1'b1;
    #1;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, ".alloc_en"}, 32'(alloc_en), 32'(exp_alloc));
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0; rd_wen = 1'b0;
    check_out(tag);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; rs1_arch = '0; rs2_arch = '0; rd_arch = '0; rd_wen = 1'b0;
    alloc_phys = '0; alloc_valid = 1'b1; out_ready = 1'b1; wb_en = 1'b0; wb_phys = '0;
    commit_en = 1'b0; commit_rd_arch = '0; commit_pd = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_pd", 32'(out_pd), 32'd0);
    chk("rst.out_old_pd", 32'(out_old_pd), 32'd0);
    chk("rst.alloc_en", 32'(alloc_en), 32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd1);

    // Basic rename and dependent source
    issue("p1", 5'd1, 5'd2, 5'd3, 1'b1, 6'd32, 1'b1, mk(6'd1, 6'd2, 1'b1, 1'b1, 6'd32, 6'd3, 1'b1));
    issue("p2", 5'd3, 5'd0, 5'd0, 1'b0, 6'd0, 1'b0, mk(6'd32, 6'd0, 1'b0, 1'b1, 6'd0, 6'd0, 1'b0));
    // rd == rs1 reads old mapping; XZR dest never allocates
    issue("p3", 5'd5, 5'd5, 5'd5, 1'b1, 6'd33, 1'b1, mk(6'd5, 6'd5, 1'b1, 1'b1, 6'd33, 6'd5, 1'b1));
    issue("xzr", 5'd0, 5'd0, 5'd31, 1'b1, 6'd40, 1'b0, mk(6'd0, 6'd0, 1'b1, 1'b1, 6'd0, 6'd0, 1'b0));

    // Empty free list stalls a writer
    in_valid = 1'b1; rs1_arch = 5'd0; rs2_arch = 5'd0; rd_arch = 5'd6; rd_wen = 1'b1;
    alloc_phys = 6'd36; alloc_valid = 1'b0;
    #1;
    chk("stall.in_ready", 32'(in_ready), 32'd0);
    chk("stall.alloc_en", 32'(alloc_en), 32'd0);
    @(posedge clk); #1;
    chk("stall.out_valid", 32'(out_valid), 32'd0);
    issue("unstall", 5'd0, 5'd0, 5'd6, 1'b1, 6'd36, 1'b1, mk(6'd0, 6'd0, 1'b1, 1'b1, 6'd36, 6'd6, 1'b1));

    // Back-pressure: packet held for 3 cycles, then released with a same-cycle wakeup
    in_valid = 1'b1; rs1_arch = 5'd6; rs2_arch = 5'd3; rd_wen = 1'b0;
    #1;
    chk("bp.in_ready0", 32'(in_ready), 32'd1);
    sb.push_back(mk(6'd36, 6'd32, 1'b0, 1'b0, 6'd0, 6'd0, 1'b0));
    @(posedge clk); #1;
    out_ready = 1'b0; rs1_arch = 5'd3; rs2_arch = 5'd0;
    for (int i = 0; i < 3; i++) begin
      #1;
      peek_out("bp.hold");
      chk("bp.in_ready", 32'(in_ready), 32'd0);
      chk("bp.alloc_en", 32'(alloc_en), 32'd0);
      @(posedge clk); #1;
    end
    peek_out("bp.hold_end");
    out_ready = 1'b1; wb_en = 1'b1; wb_phys = 6'd32;
    #1;
    chk("bp.in_ready_rel", 32'(in_ready), 32'd1);
    void'(sb.pop_front());
    sb.push_back(mk(6'd32, 6'd0, 1'b1, 1'b1, 6'd0, 6'd0, 1'b0));
    @(posedge clk); #1;
    wb_en = 1'b0; in_valid = 1'b0;
    check_out("wb_bypass");

    // Commit then flush recovery
    issue("f1", 5'd0, 5'd0, 5'd4, 1'b1, 6'd34, 1'b1, mk(6'd0, 6'd0, 1'b1, 1'b1, 6'd34, 6'd4, 1'b1));
    commit_en = 1'b1; commit_rd_arch = 5'd4; commit_pd = 6'd34;
    issue("f2", 5'd0, 5'd0, 5'd4, 1'b1, 6'd35, 1'b1, mk(6'd0, 6'd0, 1'b1, 1'b1, 6'd35, 6'd34, 1'b1));
    commit_rd_arch = 5'd31; commit_pd = 6'd45;
    @(posedge clk); #1;
    commit_rd_arch = 5'd7; commit_pd = 6'd50; flush = 1'b1;
    in_valid = 1'b1; rs1_arch = 5'd4; rd_arch = 5'd8; rd_wen = 1'b1; alloc_phys = 6'd37;
    alloc_valid = 1'b1;
    #1;
    chk("flush.in_ready", 32'(in_ready), 32'd0);
    chk("flush.alloc_en", 32'(alloc_en), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; commit_en = 1'b0; in_valid = 1'b0; rd_wen = 1'b0;
    chk("flush.out_valid", 32'(out_valid), 32'd0);
    issue("postflush", 5'd4, 5'd3, 5'd0, 1'b0, 6'd0, 1'b0, mk(6'd34, 6'd3, 1'b1, 1'b1, 6'd0, 6'd0, 1'b0));
    issue("fwdcommit", 5'd7, 5'd31, 5'd0, 1'b0, 6'd0, 1'b0, mk(6'd50, 6'd31, 1'b1, 1'b1, 6'd0, 6'd0, 1'b0));

    // Reset mid-operation restores identity maps
    issue("prerst", 5'd0, 5'd0, 5'd9, 1'b1, 6'd38, 1'b1, mk(6'd0, 6'd0, 1'b1, 1'b1, 6'd38, 6'd9, 1'b1));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mrst.out_valid", 32'(out_valid), 32'd0);
    chk("mrst.out_pd", 32'(out_pd), 32'd0);
    chk("mrst.out_rd_wen", 32'(out_rd_wen), 32'd0);
    issue("postrst", 5'd9, 5'd7, 5'd0, 1'b0, 6'd0, 1'b0, mk(6'd9, 6'd7, 1'b1, 1'b1, 6'd0, 6'd0, 1'b0));

`ifdef RENAME_STALL_CNT_EN
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("scnt.reset", stall_cycles, 32'd0);
    in_valid = 1'b1; rd_arch = 5'd10; rd_wen = 1'b1; alloc_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("scnt.seven", stall_cycles, 32'd7);
    in_valid = 1'b0; rd_wen = 1'b0; alloc_valid = 1'b1; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("scnt.rst_again", stall_cycles, 32'd0);
`endif

    chk("sb.drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
